// File: rtl/event_encoder8_3.sv
// Eight-line rising-edge event encoder with a pending set, a one-entry
// valid/ready output stage, fixed priority selection and a sticky overflow flag.
module event_encoder8_3 #(
   parameter bit PRIORITY_HIGH = 1'b0
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] in_evt,
   output logic [2:0] out_code,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] pending,
   input  logic       ovf_clr,
   output logic       overflow
);

   logic [7:0] r_in_d;
   logic [7:0] r_pending;
   logic       r_valid;
   logic [2:0] r_code;
   logic       r_ovf;

   logic [7:0] w_edge;
   logic       w_free;
   logic       w_any;
   logic       w_load;
   logic [2:0] w_sel;
   logic [7:0] w_clr;
   logic       w_ovf_set;

   assign w_edge = in_evt & ~r_in_d;
   assign w_free = ~r_valid | out_ready;
   assign w_any  = |r_pending;
   assign w_load = w_free & w_any;

   // NOTE: w_sel gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      w_sel = 3'd0;
      if (PRIORITY_HIGH) begin
         for (int i = 0; i < 8; i++)
            if (r_pending[i]) w_sel = 3'(i);
      end else begin
         for (int i = 7; i >= 0; i--)
            if (r_pending[i]) w_sel = 3'(i);
      end
   end

   // A new edge on the line being loaded re-arms it rather than counting as lost.
   assign w_clr     = w_load ? (8'b1 << w_sel) : 8'h00;
   assign w_ovf_set = |(w_edge & r_pending & ~w_clr);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_in_d    <= 8'hFF;
         r_pending <= 8'h00;
         r_valid   <= 1'b0;
         r_code    <= 3'd0;
         r_ovf     <= 1'b0;
      end else begin
         r_in_d    <= in_evt;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         if (w_free) begin
            r_valid <= w_any;
            r_code  <= w_any ? w_sel : 3'd0;
         end
         r_ovf     <= w_ovf_set | (r_ovf & ~ovf_clr);
      end
   end

   assign out_code  = r_code;
   assign out_valid = r_valid;
   assign pending   = r_pending;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_event_encoder8_3.sv
// Self-checking bench: both priority variants run side by side against an
// event-level reference model, plus directed scenarios with literal expectations.
module tb_event_encoder8_3;

   logic       sys_clk;
   logic       sys_rst;
   logic [7:0] in_evt;
   logic       out_ready;
   logic       ovf_clr;

   logic [2:0] lo_code, hi_code;
   logic       lo_valid, hi_valid;
   logic [7:0] lo_pend, hi_pend;
   logic       lo_ovf, hi_ovf;

   int n_checks = 0;
   int n_errors = 0;

   event_encoder8_3 #(.PRIORITY_HIGH(1'b0)) u_dut_lo (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .in_evt(in_evt),
      .out_code(lo_code), .out_valid(lo_valid), .out_ready(out_ready),
      .pending(lo_pend), .ovf_clr(ovf_clr), .overflow(lo_ovf)
   );

   event_encoder8_3 #(.PRIORITY_HIGH(1'b1)) u_dut_hi (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .in_evt(in_evt),
      .out_code(hi_code), .out_valid(hi_valid), .out_ready(out_ready),
      .pending(hi_pend), .ovf_clr(ovf_clr), .overflow(hi_ovf)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the set of captured events plus one presented slot.
   typedef struct packed {
      logic [7:0] pend;
      logic       valid;
      logic [2:0] code;
      logic       ovf;
   } mstate_t;

   function automatic mstate_t model_step(input mstate_t s, input logic [7:0] prev,
                                          input logic [7:0] evt, input logic rdy,
                                          input logic clr, input bit hi);
      mstate_t n = s;
      int      sel = -1;
      logic    lost = 1'b0;
      if (!s.valid || rdy) begin
         for (int i = 0; i < 8; i++)
            if (s.pend[i] && (sel < 0 || hi)) sel = i;
         if (sel >= 0) begin
            n.valid     = 1'b1;
            n.code      = 3'(sel);
            n.pend[sel] = 1'b0;
         end else begin
            n.valid = 1'b0;
            n.code  = 3'd0;
         end
      end
      for (int i = 0; i < 8; i++) begin
         if (evt[i] && !prev[i]) begin
            if (s.pend[i] && i != sel) lost = 1'b1;
            n.pend[i] = 1'b1;
         end
      end
      n.ovf = lost ? 1'b1 : (clr ? 1'b0 : s.ovf);
      return n;
   endfunction

   mstate_t    m_lo, m_hi;
   logic [7:0] m_prev;
   bit         model_ok = 1'b0;

   always @(posedge sys_clk) begin
      if (sys_rst) begin
         m_lo     <= '0;
         m_hi     <= '0;
         m_prev   <= 8'hFF;
         model_ok <= 1'b1;
      end else if (model_ok) begin
         m_lo   <= model_step(m_lo, m_prev, in_evt, out_ready, ovf_clr, 1'b0);
         m_hi   <= model_step(m_hi, m_prev, in_evt, out_ready, ovf_clr, 1'b1);
         m_prev <= in_evt;
      end
   end

   always @(negedge sys_clk) begin
      if (model_ok) begin
         check("model_lo", {19'd0, lo_pend, lo_valid, lo_code, lo_ovf}, {19'd0, m_lo});
         check("model_hi", {19'd0, hi_pend, hi_valid, hi_code, hi_ovf}, {19'd0, m_hi});
      end
   end

   // Inputs change and literal checks sample 2 time units after the rising edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
      end
   endtask

   initial begin
      sys_rst   = 1'b1;
      in_evt    = 8'h00;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      tick(3);
      sys_rst = 1'b0;
      check("rst_valid", lo_valid, 1'b0);
      check("rst_code", lo_code, 3'd0);
      check("rst_pending", lo_pend, 8'h00);
      check("rst_overflow", lo_ovf, 1'b0);
      tick(2);

      // Single pulse on bit 5 with the consumer ready.
      out_ready = 1'b1;
      in_evt    = 8'h20;
      tick();
      check("p5_pend", lo_pend, 8'h20);
      check("p5_idle", lo_valid, 1'b0);
      in_evt = 8'h00;
      tick();
      check("p5_out", {lo_valid, lo_code}, {1'b1, 3'd5});
      check("p5_pend0", lo_pend, 8'h00);
      tick();
      check("p5_once", {lo_valid, lo_code}, {1'b0, 3'd0});
      tick(2);

      // Two simultaneous events, both priority orders back to back.
      in_evt = 8'h44;
      tick();
      in_evt = 8'h00;
      tick();
      check("pr_lo_1", {lo_valid, lo_code}, {1'b1, 3'd2});
      check("pr_hi_1", {hi_valid, hi_code}, {1'b1, 3'd6});
      tick();
      check("pr_lo_2", {lo_valid, lo_code}, {1'b1, 3'd6});
      check("pr_hi_2", {hi_valid, hi_code}, {1'b1, 3'd2});
      tick();
      check("pr_drain", {lo_valid, hi_valid}, 2'b00);
      tick(2);

      // Back-pressure: event 3 held for five cycles, taken on first ready.
      out_ready = 1'b0;
      in_evt    = 8'h08;
      tick();
      in_evt = 8'h00;
      tick();
      for (int c = 0; c < 5; c++) begin
         check("bp_hold", {lo_valid, lo_code}, {1'b1, 3'd3});
         if (c < 4) tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_taken", lo_valid, 1'b0);
      tick(2);

      // Overflow: second pulse on bit 7 while it is still pending.
      out_ready = 1'b0;
      in_evt    = 8'h02;
      tick();
      in_evt = 8'h00;
      tick();
      check("ov_present", {lo_valid, lo_code}, {1'b1, 3'd1});
      in_evt = 8'h80;
      tick();
      in_evt = 8'h00;
      tick();
      check("ov_none_yet", lo_ovf, 1'b0);
      in_evt = 8'h80;
      tick();
      in_evt = 8'h00;
      tick();
      check("ov_pend", lo_pend, 8'h80);
      check("ov_flag", lo_ovf, 1'b1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ov_clr", lo_ovf, 1'b0);
      out_ready = 1'b1;
      tick();
      check("ov_drain7", {lo_valid, lo_code}, {1'b1, 3'd7});
      tick(3);

      // Lines held high across reset release produce nothing.
      in_evt  = 8'hFF;
      sys_rst = 1'b1;
      tick(2);
      sys_rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("hold_novalid", {lo_valid, lo_pend}, 9'd0);
      end
      in_evt = 8'h00;
      tick();
      in_evt = 8'h01;
      tick();
      in_evt = 8'h00;
      tick();
      check("hold_bit0", {lo_valid, lo_code}, {1'b1, 3'd0});
      tick(3);

      // Reset while an event is presented and two more are pending.
      out_ready = 1'b0;
      in_evt    = 8'h02;
      tick();
      in_evt = 8'h00;
      tick();
      in_evt = 8'h0C;
      tick();
      in_evt = 8'h00;
      check("mid_pend", {lo_valid, lo_pend}, {1'b1, 8'h0C});
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check("mid_rst", {lo_pend, lo_valid, lo_code, lo_ovf}, 13'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("mid_nostale", {lo_valid, lo_code, hi_valid}, 5'd0);
      end

      // Randomized traffic, checked every cycle by the model.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 3) != 0)
            in_evt = 8'($urandom) & 8'($urandom) & 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         ovf_clr   = ($urandom_range(0, 15) == 0);
         sys_rst   = ($urandom_range(0, 299) == 0);
         tick();
      end
      sys_rst = 1'b0;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/event_encoder8_3.md
EVENT_ENCODER8_3 -- requirements
Module: event_encoder8_3

Interface
REQ-001 SHALL have parameter PRIORITY_HIGH, default 0: 0 = lowest pending index wins; 1 = highest pending index wins.
REQ-002 SHALL have port sys_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_evt, input, 8: event lines, synchronous to sys_clk; a 0->1 transition on bit i is one event i.
REQ-005 SHALL have port out_code, output, 3: binary index of the presented event.
REQ-006 SHALL have port out_valid, output, 1: out_code holds a valid event.
REQ-007 SHALL have port out_ready, input, 1: consumer accepts; transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-008 SHALL have port pending, output, 8: events captured but not yet loaded to the output stage.
REQ-009 SHALL have port ovf_clr, input, 1: clears overflow.
REQ-010 SHALL have port overflow, output, 1: sticky flag; an event was lost.

Function
REQ-011 SHALL register in_evt into an 8-bit delay register in_d every cycle; edge[i] = in_evt[i] & ~in_d[i].
REQ-012 SHALL set pending[i] on the clock edge where edge[i]=1, so pending[i] reads 1 in the following cycle.
REQ-013 SHALL treat the output stage as free when out_valid=0 or a transfer occurs this cycle.
REQ-014 When the output stage is free and pending!=0: SHALL load out_code with the index selected per PRIORITY_HIGH, set out_valid=1 and clear that pending bit on the same edge.
REQ-015 When the output stage is free and pending==0: SHALL drive out_valid=0 on the next edge.
REQ-016 While out_valid=1 and out_ready=0: SHALL hold out_code and out_valid unchanged.
REQ-017 Latency: an in_evt bit rising before edge k, with the output stage idle, SHALL give out_valid=1 with its code after edge k+1 (two cycles).
REQ-018 With continuous out_ready=1, SHALL deliver one event per cycle, with no idle cycle between back-to-back pending events.
REQ-019 A new edge[i] and a load that clears pending[i] on the same edge: set wins, pending[i]=1 afterwards.
REQ-020 Overflow: edge[i]=1 while pending[i]=1 and not cleared on that edge SHALL set overflow; the event is merged; pending is unchanged.
REQ-021 ovf_clr=1 SHALL clear overflow on the next edge; a simultaneous overflow set SHALL win.
REQ-022 Level held high SHALL produce exactly one event; the line must return to 0 for at least one cycle before it can produce another.
REQ-023 out_code SHALL be 3'd0 whenever out_valid=0.

Reset
REQ-024 sys_rst=1 at an edge SHALL force pending=8'h00, out_valid=0, out_code=3'd0, overflow=0 and in_d=8'hFF, overriding all other inputs.
REQ-025 in_d reset to 8'hFF SHALL suppress events on lines already high when reset is released.
REQ-026 Reset mid-transfer (out_valid=1, out_ready=0) SHALL discard the presented and pending events; no transfer is counted.

Verification
REQ-027 Bench: after reset, pulse in_evt=8'h20 for 1 cycle, out_ready=1 -> out_valid=1 with out_code=5 exactly two cycles after the rise, for one cycle; pending returns to 8'h00.
REQ-028 Bench: in_evt 8'h00->8'h44, PRIORITY_HIGH=0, out_ready=1 -> codes 2 then 6 on consecutive cycles; with PRIORITY_HIGH=1 -> 6 then 2.
REQ-029 Bench: event 3 with out_ready=0 for 5 cycles -> out_code=3 and out_valid=1 stable for all 5 cycles; transfer on the first cycle out_ready=1.
REQ-030 Bench: out_ready=0, event 1 presented, then two pulses on bit 7 -> pending=8'h80, overflow=1; ovf_clr pulse -> overflow=0.
REQ-031 Bench: hold in_evt=8'hFF across reset release -> no out_valid; drop to 8'h00, then raise bit 0 -> out_code=0.
REQ-032 Bench: sys_rst asserted while out_valid=1 and pending=8'h0C -> next cycle all outputs are at reset values and no stale code appears afterwards.
